// File: rtl/bless_ni_pkg.sv
// Shared definitions for the BLESS network-interface controller: flit widths
// and helpers for the timestamp field of the router control word.
package bless_ni_pkg;

    localparam int CW        = 24;
    localparam int DW        = 64;
    localparam int TS_W      = 8;
    localparam int VALID_BIT = CW - 1;

    function automatic logic [TS_W-1:0] get_ts(input logic [CW-1:0] ctrl);
        return ctrl[TS_W-1:0];
    endfunction

    function automatic logic [CW-1:0] set_ts(input logic [CW-1:0] ctrl,
                                             input logic [TS_W-1:0] ts);
        logic [CW-1:0] res;
        res           = ctrl;
        res[TS_W-1:0] = ts;
        return res;
    endfunction

endpackage

// File: rtl/bless_ni_fifo.sv
// Small circular FIFO with extra-bit pointers; a push into a full FIFO is
// accepted only when a pop frees the head slot on the same edge.
module bless_ni_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset: the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/bless_ni_ctrl.sv
// Network interface between a core and port 4 of the bufferless deflection
// router: timestamped injection queue, ejection buffer, starvation/overflow flags.
module bless_ni_ctrl
    import bless_ni_pkg::*;
#(
    parameter int INJ_DEPTH = 4,
    parameter int EJ_DEPTH  = 4,
    parameter int STARVE_TH = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          core_inj_valid,
    output logic          core_inj_ready,
    input  logic [CW-1:0] core_inj_c,
    input  logic [DW-1:0] core_inj_d,
    input  logic          port4_ready,
    output logic [CW-1:0] port4_ci,
    output logic [DW-1:0] port4_di,
    input  logic [CW-1:0] port4_co,
    input  logic [DW-1:0] port4_do,
    output logic          core_ej_valid,
    input  logic          core_ej_ready,
    output logic [CW-1:0] core_ej_c,
    output logic [DW-1:0] core_ej_d,
    output logic          starve,
    output logic          ej_overflow
);

    localparam int SC_W = $clog2(STARVE_TH) + 1;

    logic [CW+DW-1:0] inj_head;
    logic [CW+DW-1:0] ej_head;
    logic             inj_full, inj_empty, inj_push, inj_pop;
    logic             ej_full, ej_empty, ej_push, ej_pop;
    logic [TS_W-1:0]  ts_cnt;
    logic [SC_W-1:0]  starve_cnt;

    assign core_inj_ready = !inj_full;
    assign inj_push       = core_inj_valid && !inj_full;
    assign inj_pop        = !inj_empty && port4_ready;

    assign ej_push        = port4_co[VALID_BIT];
    assign ej_pop         = core_ej_ready && !ej_empty;
    assign core_ej_valid  = !ej_empty;
    assign core_ej_c      = ej_empty ? '0 : ej_head[CW+DW-1:DW];
    assign core_ej_d      = ej_empty ? '0 : ej_head[DW-1:0];

    assign starve         = (starve_cnt >= SC_W'(STARVE_TH));

    bless_ni_fifo #(.WIDTH(CW+DW), .DEPTH(INJ_DEPTH)) u_inj_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inj_push),
        .pop   (inj_pop),
        .wdata ({core_inj_c, core_inj_d}),
        .full  (inj_full),
        .empty (inj_empty),
        .head  (inj_head)
    );

    bless_ni_fifo #(.WIDTH(CW+DW), .DEPTH(EJ_DEPTH)) u_ej_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (ej_push),
        .pop   (ej_pop),
        .wdata ({port4_co, port4_do}),
        .full  (ej_full),
        .empty (ej_empty),
        .head  (ej_head)
    );

    // The head flit is stamped with the cycle it actually leaves, not when queued.
    always_comb begin
        port4_ci = '0;
        port4_di = '0;
        if (inj_pop) begin
            port4_ci            = set_ts(inj_head[CW+DW-1:DW], ts_cnt);
            port4_ci[VALID_BIT] = 1'b1;
            port4_di            = inj_head[DW-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_cnt      <= '0;
            ej_overflow <= 1'b0;
            starve_cnt  <= '0;
        end else begin
            ts_cnt <= ts_cnt + TS_W'(1);
            if (ej_push && ej_full && !ej_pop) ej_overflow <= 1'b1;
            if (inj_pop || inj_empty)
                starve_cnt <= '0;
            else if (starve_cnt < SC_W'(STARVE_TH))
                starve_cnt <= starve_cnt + SC_W'(1);
        end
    end

endmodule

// File: tb/tb_bless_ni_ctrl.sv
// Randomized and directed bench for bless_ni_ctrl, checked every cycle against
// a queue-based model of the network interface.
module tb_bless_ni_ctrl;
    import bless_ni_pkg::*;

    localparam int FW    = CW + DW;
    localparam int INJ_D = 4;
    localparam int EJ_D  = 4;
    localparam int STH   = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          core_inj_valid;
    logic          core_inj_ready;
    logic [CW-1:0] core_inj_c;
    logic [DW-1:0] core_inj_d;
    logic          port4_ready;
    logic [CW-1:0] port4_ci;
    logic [DW-1:0] port4_di;
    logic [CW-1:0] port4_co;
    logic [DW-1:0] port4_do;
    logic          core_ej_valid;
    logic          core_ej_ready;
    logic [CW-1:0] core_ej_c;
    logic [DW-1:0] core_ej_d;
    logic          starve;
    logic          ej_overflow;

    always #5 clk = ~clk;

    bless_ni_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .core_inj_valid (core_inj_valid),
        .core_inj_ready (core_inj_ready),
        .core_inj_c     (core_inj_c),
        .core_inj_d     (core_inj_d),
        .port4_ready    (port4_ready),
        .port4_ci       (port4_ci),
        .port4_di       (port4_di),
        .port4_co       (port4_co),
        .port4_do       (port4_do),
        .core_ej_valid  (core_ej_valid),
        .core_ej_ready  (core_ej_ready),
        .core_ej_c      (core_ej_c),
        .core_ej_d      (core_ej_d),
        .starve         (starve),
        .ej_overflow    (ej_overflow)
    );

    int total = 0;
    int bad   = 0;

    logic [FW-1:0] inj_q[$];
    logic [FW-1:0] ej_q[$];
    int            ts_m;
    int            sc_m;
    bit            ovf_m;

    logic [CW-1:0] last_ci;
    logic [DW-1:0] last_di;
    logic          last_starve;
    logic          last_ready;
    logic          last_ovf;

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        inj_q.delete();
        ej_q.delete();
        ts_m  = 0;
        sc_m  = 0;
        ovf_m = 1'b0;
    endtask

    task automatic checkAll();
        logic [CW-1:0] exp_ci;
        logic [DW-1:0] exp_di;
        logic [CW-1:0] exp_ejc;
        logic [DW-1:0] exp_ejd;
        exp_ci  = '0;
        exp_di  = '0;
        exp_ejc = '0;
        exp_ejd = '0;
        if (inj_q.size() > 0 && port4_ready) begin
            exp_ci            = inj_q[0][FW-1:DW];
            exp_ci[CW-1]      = 1'b1;
            exp_ci[TS_W-1:0]  = TS_W'(ts_m);
            exp_di            = inj_q[0][DW-1:0];
        end
        if (ej_q.size() > 0) begin
            exp_ejc = ej_q[0][FW-1:DW];
            exp_ejd = ej_q[0][DW-1:0];
        end
        checkOutput("core_inj_ready", core_inj_ready, inj_q.size() < INJ_D);
        checkOutput("port4_ci", port4_ci, exp_ci);
        checkOutput("port4_di", port4_di, exp_di);
        checkOutput("core_ej_valid", core_ej_valid, ej_q.size() > 0);
        checkOutput("core_ej_c", core_ej_c, exp_ejc);
        checkOutput("core_ej_d", core_ej_d, exp_ejd);
        checkOutput("starve", starve, sc_m >= STH);
        checkOutput("ej_overflow", ej_overflow, ovf_m);
    endtask

    task automatic applyStimulus(input bit iv, input logic [CW-1:0] ic, input logic [DW-1:0] id,
                                 input bit p4r, input logic [CW-1:0] eo_c, input logic [DW-1:0] eo_d,
                                 input bit ejr);
        bit ipush, ipop, ejpop;
        @(negedge clk);
        core_inj_valid = iv;
        core_inj_c     = ic;
        core_inj_d     = id;
        port4_ready    = p4r;
        port4_co       = eo_c;
        port4_do       = eo_d;
        core_ej_ready  = ejr;
        #1;
        checkAll();
        last_ci     = port4_ci;
        last_di     = port4_di;
        last_starve = starve;
        last_ready  = core_inj_ready;
        last_ovf    = ej_overflow;
        @(posedge clk);
        ipush = iv && (inj_q.size() < INJ_D);
        ipop  = (inj_q.size() > 0) && p4r;
        if (ipop || inj_q.size() == 0) sc_m = 0;
        else if (sc_m < STH) sc_m++;
        if (ipop) void'(inj_q.pop_front());
        if (ipush) inj_q.push_back({ic, id});
        ejpop = (ej_q.size() > 0) && ejr;
        if (ejpop) void'(ej_q.pop_front());
        if (eo_c[CW-1]) begin
            if (ej_q.size() < EJ_D) ej_q.push_back({eo_c, eo_d});
            else ovf_m = 1'b1;
        end
        ts_m = (ts_m + 1) % 256;
    endtask

    task automatic idleCycle(input bit p4r);
        applyStimulus(1'b0, '0, '0, p4r, '0, '0, 1'b0);
    endtask

    // Reset is raised between edges; outputs must clear without waiting for a clock.
    task automatic doReset();
        core_inj_valid = 1'b0;
        core_inj_c     = '0;
        core_inj_d     = '0;
        port4_ready    = 1'b1;
        port4_co       = '0;
        port4_do       = '0;
        core_ej_ready  = 1'b0;
        rst            = 1'b1;
        #1;
        checkOutput("rst_port4_ci", port4_ci, 0);
        checkOutput("rst_port4_di", port4_di, 0);
        checkOutput("rst_core_inj_ready", core_inj_ready, 1);
        checkOutput("rst_core_ej_valid", core_ej_valid, 0);
        checkOutput("rst_core_ej_c", core_ej_c, 0);
        checkOutput("rst_core_ej_d", core_ej_d, 0);
        checkOutput("rst_starve", starve, 0);
        checkOutput("rst_ej_overflow", ej_overflow, 0);
        modelReset();
        port4_ready = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    initial begin
        doReset();

        // single injection, stamped with ts 5
        for (int i = 0; i < 4; i++) idleCycle(1'b0);
        applyStimulus(1'b1, 24'h801234, 64'hDEADBEEF_00000001, 1'b0, '0, '0, 1'b0);
        idleCycle(1'b1);
        checkOutput("single_inj_ci", last_ci, 24'h801205);
        checkOutput("single_inj_di", last_di, 64'hDEADBEEF_00000001);
        idleCycle(1'b1);
        checkOutput("single_inj_empty_after", last_ci, 0);

        // blocked then starved, then released
        doReset();
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, CW'(24'h010100 + i), DW'(64'h1000 + i), 1'b0, '0, '0, 1'b0);
        idleCycle(1'b0);
        checkOutput("inj_full_ready", last_ready, 0);
        for (int i = 0; i < 15; i++) idleCycle(1'b0);
        checkOutput("starve_raised", last_starve, 1);
        for (int i = 0; i < 4; i++) begin
            idleCycle(1'b1);
            checkOutput("starve_order_di", last_di, DW'(64'h1000 + i));
        end
        idleCycle(1'b0);
        checkOutput("starve_cleared", last_starve, 0);

        // ejection backpressure and sticky overflow
        doReset();
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b0, '0, '0, 1'b0, CW'(24'h800000 + i), DW'(64'hE000 + i), 1'b0);
        idleCycle(1'b0);
        checkOutput("ej_overflow_set", last_ovf, 1);
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
        idleCycle(1'b0);
        checkOutput("ej_overflow_sticky", last_ovf, 1);

        // full ejection FIFO with simultaneous pop and push
        doReset();
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b0, '0, '0, 1'b0, CW'(24'h8A0000 + i), DW'(64'hF000 + i), 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b0, 24'h8B0000, 64'hF0F0, 1'b1);
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
        checkOutput("full_pop_push_no_ovf", last_ovf, 0);

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            logic [CW-1:0] rc;
            rc = CW'($urandom);
            applyStimulus($urandom_range(0, 1) == 1, CW'($urandom), {$urandom, $urandom},
                          $urandom_range(0, 3) != 0, rc, {$urandom, $urandom},
                          $urandom_range(0, 2) != 0);
        end

        // timestamp wrap
        for (int i = 0; i < 8 && inj_q.size() > 0; i++) idleCycle(1'b1);
        for (int i = 0; i < 300 && ts_m != 253; i++) idleCycle(1'b0);
        applyStimulus(1'b1, 24'h8055AA, 64'hA, 1'b0, '0, '0, 1'b0);
        applyStimulus(1'b1, 24'h8066BB, 64'hB, 1'b0, '0, '0, 1'b0);
        idleCycle(1'b1);
        checkOutput("ts_wrap_ff", last_ci[TS_W-1:0], 8'hFF);
        idleCycle(1'b1);
        checkOutput("ts_wrap_00", last_ci[TS_W-1:0], 8'h00);

        // asynchronous reset with two flits queued and the router ready
        applyStimulus(1'b1, 24'h812345, 64'h11, 1'b0, 24'h800001, 64'h22, 1'b0);
        applyStimulus(1'b1, 24'h834567, 64'h33, 1'b0, '0, '0, 1'b0);
        #2 port4_ready = 1'b1;
        #1 checkAll();
        doReset();
        for (int i = 0; i < 4; i++) idleCycle(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bless_ni_ctrl.md
Name: bless_ni_ctrl

Overview:
Network-interface controller that sits between a core and the injection/ejection port (port 4) of the 5-port bufferless deflection router (brouter).
- Injection: queues core flits, stamps each with an injection timestamp, and injects only in cycles where the router signals port4_ready.
- Ejection: buffers flits the router ejects unconditionally on port4_co/port4_do.
- Reports injection starvation and ejection overflow.

Parameters:
CW, 24, control word width (matches router control width)
DW, 64, data word width (matches router data width)
TS_W, 8, timestamp field width, control bits [TS_W-1:0]
INJ_DEPTH, 4, injection FIFO entries (power of 2)
EJ_DEPTH, 4, ejection FIFO entries (power of 2)
STARVE_TH, 16, blocked-cycle count that raises starve

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
core_inj_valid  in  1  core offers flit
core_inj_ready  out  1  injection FIFO not full
core_inj_c  in  CW  control word from core (timestamp bits ignored)
core_inj_d  in  DW  data word from core
port4_ready  in  1  router has a free output slot for injection this cycle
port4_ci  out  CW  control to router injection input
port4_di  out  DW  data to router injection input
port4_co  in  CW  control from router ejection output
port4_do  in  DW  data from router ejection output
core_ej_valid  out  1  ejection FIFO head valid
core_ej_ready  in  1  core accepts ejected flit
core_ej_c  out  CW  ejected control word
core_ej_d  out  DW  ejected data word
starve  out  1  injection starved (sat. counter >= STARVE_TH)
ej_overflow  out  1  sticky: ejected flit dropped because FIFO full

Behaviour:
- Control word layout (shared package): bit CW-1 = valid; bits [TS_W-1:0] = timestamp; remaining bits are routing fields, passed through untouched.
- Reset (rst=1, async): FIFOs empty, ts_cnt=0, starve_cnt=0, ej_overflow=0. While reset is asserted, all outputs are 0 except core_inj_ready=1.
- ts_cnt is a free-running TS_W-bit counter, +1 every clk, wraps 2^TS_W-1 -> 0.
- Injection push: on the edge where core_inj_valid & core_inj_ready. core_inj_ready = !inj_full, registered-state based. There is no comb path from port4_ready, so no same-cycle push on full.
- Injection present: when inj FIFO is non-empty and port4_ready=1, port4_ci/di are driven combinationally.
  - port4_ci = head control with valid forced to 1 and [TS_W-1:0] replaced by ts_cnt.
  - Otherwise port4_ci=0 and port4_di=0.
  - The pop happens on that same edge. Injection latency from push to earliest injection is 1 cycle.
- Simultaneous push and pop when full: the pop frees the slot, but core_inj_ready stays 0 that cycle (registered). Simultaneous push and pop otherwise: occupancy is unchanged.
- FIFO pointers are log2(depth)+1 bits; full/empty use MSB compare; wrap is natural.
- Ejection: a flit with port4_co[CW-1]=1 is pushed into the ej FIFO on the edge.
  - If the FIFO is full and no pop occurs the same edge, the flit is dropped and ej_overflow is set. ej_overflow is cleared only by rst.
  - If full with a simultaneous pop (core_ej_valid & core_ej_ready), the flit is accepted.
- core_ej_valid = !ej_empty; core_ej_c/d = head, 0 when empty.
- Starvation counter starve_cnt (log2(STARVE_TH)+1 bits):
  - +1, saturating, each cycle inj FIFO is non-empty and port4_ready=0.
  - Cleared on any injection, and cleared when the FIFO is empty.
  - starve = (starve_cnt >= STARVE_TH), registered.
- Reset mid-operation: all queued flits are discarded immediately. No partial flit is driven to the router.

Decomposition:
- Package bless_ni_pkg: CW, DW, TS_W, VALID_BIT=CW-1, functions to extract and set the timestamp field.
- One sub-module: bless_ni_fifo (param WIDTH, DEPTH; push/pop/full/empty/head; async active-high rst), instantiated twice (WIDTH=CW+DW).

Test Plan:
- Reset then idle: rst pulse -> all outputs 0, core_inj_ready=1, ts_cnt=0 after release.
- Single inject: push ctrl 0x80_1234 with data 0xDEADBEEF_00000001, port4_ready=1 next cycle with ts_cnt=0x05 -> port4_ci=0x801205, port4_di matches, FIFO empty next cycle.
- Blocked then starve: fill 4 flits, hold port4_ready=0 for 16 cycles.
  - Required: core_inj_ready=0 after the 4th push, starve=1 at cycle 16, flits kept in order.
  - Raise port4_ready: 4 injections in order, starve=0 after the first.
- Ejection backpressure: core_ej_ready=0, router ejects 5 valid flits -> first 4 held, 5th dropped, ej_overflow=1 and sticky. Then core_ej_ready=1 -> the 4 flits drain in order.
- Full with simultaneous pop/push on ejection: ej FIFO full, core_ej_ready=1 and a new ejected flit on the same edge -> flit accepted, no overflow.
- Timestamp wrap and async reset: inject at ts_cnt=0xFF and the next cycle -> stamps 0xFF then 0x00. Assert rst between clock edges with 2 flits queued -> FIFOs empty and port4_ci=0 immediately.
